aes_inv_cipher_iter: RTL

- Iterative AES-128 inverse cipher. Decrypts one 128-bit block, one round per clock.
- Counterpart of the forward round datapath (Pre_round / SubByte / ShiftRow / MixCol / AddRoundKey). It undoes that datapath by applying the inverse transforms in reverse key order.
- Round keys come from an external key-schedule store, which this block indexes.
- Valid/ready handshake on both input and output.

---
 rtl/aes_inv_pkg.sv | 87 ++++++++
 rtl/aes_inv_mixcol.sv | 22 ++
 rtl/aes_inv_cipher_iter.sv | 98 +++++++++
 3 files changed

// File: rtl/aes_inv_pkg.sv
// Shared AES-128 inverse-cipher definitions: inverse S-box, GF(2^8) helpers,
// InvSubBytes / InvShiftRows and the iterative FSM encoding.
package aes_inv_pkg;

  localparam int NR       = 10;
  localparam int KEY_LAST = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2,
    ST_DONE  = 2'd3
  } fsm_e;

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul_x9(input logic [7:0] b);
    logic [7:0] b8;
    b8 = xtime(xtime(xtime(b)));
    return b8 ^ b;
  endfunction

  function automatic logic [7:0] gf_mul_xb(input logic [7:0] b);
    logic [7:0] b2, b8;
    b2 = xtime(b);
    b8 = xtime(xtime(b2));
    return b8 ^ b2 ^ b;
  endfunction

  function automatic logic [7:0] gf_mul_xd(input logic [7:0] b);
    logic [7:0] b4, b8;
    b4 = xtime(xtime(b));
    b8 = xtime(b4);
    return b8 ^ b4 ^ b;
  endfunction

  function automatic logic [7:0] gf_mul_xe(input logic [7:0] b);
    logic [7:0] b2, b4, b8;
    b2 = xtime(b);
    b4 = xtime(b2);
    b8 = xtime(b4);
    return b8 ^ b4 ^ b2;
  endfunction

  // Byte i of the state sits at bits [127-8i -: 8]; state is column-major.
  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      r[127-8*i -: 8] = INV_SBOX[s[127-8*i -: 8]];
    end
    return r;
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[127-8*(4*c+row) -: 8] = s[127-8*(4*((c-row+4)%4)+row) -: 8];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_inv_mixcol.sv
// Combinational AES InvMixColumns over a full 128-bit state (four columns).
module aes_inv_mixcol
  import aes_inv_pkg::*;
(
  input  logic [127:0] data_i,
  output logic [127:0] data_o
);

  function automatic logic [31:0] inv_mix_word(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {gf_mul_xe(a0) ^ gf_mul_xb(a1) ^ gf_mul_xd(a2) ^ gf_mul_x9(a3),
            gf_mul_x9(a0) ^ gf_mul_xe(a1) ^ gf_mul_xb(a2) ^ gf_mul_xd(a3),
            gf_mul_xd(a0) ^ gf_mul_x9(a1) ^ gf_mul_xe(a2) ^ gf_mul_xb(a3),
            gf_mul_xb(a0) ^ gf_mul_xd(a1) ^ gf_mul_x9(a2) ^ gf_mul_xe(a3)};
  endfunction

  for (genvar c = 0; c < 4; c++) begin : g_col
    assign data_o[127-32*c -: 32] = inv_mix_word(data_i[127-32*c -: 32]);
  end

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 inverse cipher, one round per clock, external round-key store.
// Optional synchronous flush port enabled by defining AES_INV_FLUSH_EN.
module aes_inv_cipher_iter
  import aes_inv_pkg::*;
#(
  parameter int NR     = 10,
  parameter int KIDX_W = 4
) (
  input  logic              clk,
  input  logic              rst,
`ifdef AES_INV_FLUSH_EN
  input  logic              flush,
`endif
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [127:0]      ciphertext,
  output logic [KIDX_W-1:0] key_idx,
  input  logic [127:0]      round_key,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [127:0]      plaintext,
  output logic              busy
);

  fsm_e         fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] ark;
  logic [127:0] mix_out;

  // One shared round datapath: the final round simply skips InvMixColumns.
  assign ark = inv_sub_bytes(inv_shift_rows(state_q)) ^ round_key;

  aes_inv_mixcol u_mixcol (
    .data_i (ark),
    .data_o (mix_out)
  );

  always_comb begin
    fsm_d    = fsm_q;
    state_d  = state_q;
    rnd_d    = rnd_q;
    key_idx  = KIDX_W'(KEY_LAST);
    in_ready = 1'b0;
    unique case (fsm_q)
      ST_IDLE: in_ready = 1'b1;
      ST_ROUND: begin
        key_idx = KIDX_W'(rnd_q);
        state_d = mix_out;
        rnd_d   = rnd_q - 4'd1;
        if (rnd_q == 4'd1) fsm_d = ST_FINAL;
      end
      ST_FINAL: begin
        key_idx = '0;
        state_d = ark;
        fsm_d   = ST_DONE;
      end
      ST_DONE: begin
        in_ready = out_ready;
        if (out_ready) fsm_d = ST_IDLE;
      end
      default: fsm_d = ST_IDLE;
    endcase
`ifdef AES_INV_FLUSH_EN
    in_ready = in_ready & ~flush;
`endif
    // key_idx is KEY_LAST whenever in_ready can be high, so round_key is key 10 here.
    if (in_valid && in_ready) begin
      state_d = ciphertext ^ round_key;
      rnd_d   = 4'(NR - 1);
      fsm_d   = ST_ROUND;
    end
`ifdef AES_INV_FLUSH_EN
    if (flush) begin
      fsm_d   = ST_IDLE;
      state_d = '0;
      rnd_d   = '0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q   <= ST_IDLE;
      state_q <= '0;
      rnd_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      rnd_q   <= rnd_d;
    end
  end

  assign out_valid = (fsm_q == ST_DONE);
  assign busy      = (fsm_q == ST_ROUND) || (fsm_q == ST_FINAL);
  assign plaintext = state_q;

endmodule
